// File: rtl/game_tick_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_tick_timer_pkg
// Description : Shared game definitions. Holds the speed codes used by the
//               speed-select stage and the tick timer, the tick-timer state
//               encoding, and a helper that folds the unused speed code onto
//               Normal.
// Revision    : 1.0 - initial release
// ============================================================================
package game_tick_timer_pkg;

  // Speed codes shared with the upstream selection stage
  localparam logic [1:0] SPEED_NORMAL = 2'b00;
  localparam logic [1:0] SPEED_INTER  = 2'b01;
  localparam logic [1:0] SPEED_ADV    = 2'b10;

  // Tick-timer FSM encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ARM  = 2'd1;
  localparam state_t ST_RUN  = 2'd2;

  // 2'b11 is not a selectable level; treat it as the slowest (safest) speed.
  function automatic logic [1:0] sanitize_speed(input logic [1:0] speed);
    return (speed == 2'b11) ? SPEED_NORMAL : speed;
  endfunction

endpackage : game_tick_timer_pkg
`default_nettype wire

// File: rtl/game_tick_timer_ms_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : ms_prescaler
// Description : Divides the system clock down to a one-millisecond strobe.
//               Counts 0..CYC_PER_MS-1 while enabled and wraps; holds its
//               value while disabled; clear forces it back to zero.
// Ports       : clk      - system clock
//               rst      - synchronous active-low reset
//               clear    - synchronous clear (priority over enable)
//               enable   - advance the count this cycle
//               ms_pulse - high on the cycle the terminal count is consumed
// Revision    : 1.0 - initial release
// ============================================================================
module ms_prescaler #(
  parameter int CYC_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic ms_pulse
);

  localparam int CNT_W = (CYC_PER_MS > 1) ? $clog2(CYC_PER_MS) : 1;
  localparam logic [CNT_W-1:0] c_terminal = CNT_W'(CYC_PER_MS - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      if (r_cnt == c_terminal) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Strobe only on a cycle that actually advances past the terminal count,
  // so a pause sitting on the terminal value does not repeat the millisecond.
  assign ms_pulse = enable & ~clear & (r_cnt == c_terminal);

endmodule : ms_prescaler
`default_nettype wire

// File: rtl/game_tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : game_tick_timer
// Description : Latches the selected game speed when the selection becomes
//               final and produces a periodic one-cycle tick pacing the game
//               logic. Normal = NORMAL_MS, Intermediate = INTER_MS,
//               Advanced = ADV_MS milliseconds per tick.
// Ports       : clk          - system clock
//               rst          - synchronous active-low reset
//               game_speed   - speed code from the selection stage
//               control      - 1 = selection final, 0 = idle/clear
//               pause        - freezes timing while running
//               tick         - registered one-cycle pulse per period
//               running      - high while in RUN
//               active_speed - speed code latched at arm time
// Revision    : 1.0 - initial release
// ============================================================================
module game_tick_timer
  import game_tick_timer_pkg::*;
#(
  parameter int CYC_PER_MS = 50000,
  parameter int NORMAL_MS  = 1000,
  parameter int INTER_MS   = 500,
  parameter int ADV_MS     = 250,
  parameter int MS_W       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] game_speed,
  input  logic       control,
  input  logic       pause,
  output logic       tick,
  output logic       running,
  output logic [1:0] active_speed
);

  // Terminal values of the millisecond counter for each level
  localparam logic [MS_W-1:0] c_normal_m1 = MS_W'(NORMAL_MS - 1);
  localparam logic [MS_W-1:0] c_inter_m1  = MS_W'(INTER_MS - 1);
  localparam logic [MS_W-1:0] c_adv_m1    = MS_W'(ADV_MS - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [MS_W-1:0] r_ms;
  logic [MS_W-1:0] w_period_m1;
  logic            w_count_en;
  logic            w_clear;
  logic            w_ms_pulse;
  logic            w_tick_next;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (control) w_state_next = ST_ARM;
      // ARM lasts exactly one cycle regardless of control; a dropped control
      // is picked up from RUN on the following cycle.
      ST_ARM:  w_state_next = ST_RUN;
      ST_RUN:  if (!control) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs and counter controls
  // --------------------------------------------------------------------------
  always_comb begin
    running     = (r_state == ST_RUN);
    // Counting happens only in RUN with control still high; pause simply
    // withholds the enable so both counters keep their value.
    w_count_en  = running & control & ~pause;
    // Anything other than a continuing RUN returns the counters to zero.
    w_clear     = ~running | ~control;
    w_tick_next = w_count_en & w_ms_pulse & (r_ms == w_period_m1);
  end

  // --------------------------------------------------------------------------
  // Speed latch: captured only in ARM, so speed changes during RUN are ignored
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      active_speed <= SPEED_NORMAL;
    end else if (r_state == ST_ARM) begin
      active_speed <= sanitize_speed(game_speed);
    end
  end

  // --------------------------------------------------------------------------
  // Period select
  // --------------------------------------------------------------------------
  always_comb begin
    case (active_speed)
      SPEED_INTER: w_period_m1 = c_inter_m1;
      SPEED_ADV:   w_period_m1 = c_adv_m1;
      default:     w_period_m1 = c_normal_m1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Millisecond prescaler
  // --------------------------------------------------------------------------
  ms_prescaler #(
    .CYC_PER_MS (CYC_PER_MS)
  ) u_ms_prescaler (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_clear),
    .enable   (w_count_en),
    .ms_pulse (w_ms_pulse)
  );

  // --------------------------------------------------------------------------
  // Millisecond counter: wraps to zero on the same edge that raises tick
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ms <= '0;
    end else if (w_clear) begin
      r_ms <= '0;
    end else if (w_count_en && w_ms_pulse) begin
      if (r_ms == w_period_m1) begin
        r_ms <= '0;
      end else begin
        r_ms <= r_ms + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Tick register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick <= 1'b0;
    end else begin
      tick <= w_tick_next;
    end
  end

endmodule : game_tick_timer
`default_nettype wire

// File: tb/tb_game_tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_tick_timer
// Description : Self-checking bench for game_tick_timer with a small clock
//               divider (4 cycles/ms; 5/3/2 ms periods). A behavioural model
//               counts enabled RUN cycles and expects a tick whenever that
//               count is a multiple of period*CYC_PER_MS. Directed scenarios
//               pin tick positions to hand-computed offsets; a randomized
//               phase exercises arbitrary control/pause/speed/reset mixes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_tick_timer;

  localparam int CYC = 4;

  logic       clk;
  logic       rst;
  logic [1:0] game_speed;
  logic       control;
  logic       pause;
  logic       tick;
  logic       running;
  logic [1:0] active_speed;

  int n_tests = 0;
  int n_fail  = 0;

  game_tick_timer #(
    .CYC_PER_MS (CYC),
    .NORMAL_MS  (5),
    .INTER_MS   (3),
    .ADV_MS     (2),
    .MS_W       (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .game_speed   (game_speed),
    .control      (control),
    .pause        (pause),
    .tick         (tick),
    .running      (running),
    .active_speed (active_speed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model: phase 0 = idle, 1 = arm, 2 = run
  // --------------------------------------------------------------------------
  int       m_phase   = 0;
  int       m_elapsed = 0;
  logic [1:0] m_speed = 2'b00;
  logic     m_tick    = 1'b0;

  function automatic int period_ms(input logic [1:0] s);
    case (s)
      2'b01:   return 3;
      2'b10:   return 2;
      default: return 5;
    endcase
  endfunction

  int cyc       = 0;
  int run_entry = 0;
  logic prev_run = 1'b0;
  int tick_log[$];

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_phase = 0; m_speed = 2'b00; m_elapsed = 0; m_tick = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          m_tick = 1'b0;
          if (control) m_phase = 1;
        end
        1: begin
          m_speed   = (game_speed == 2'b11) ? 2'b00 : game_speed;
          m_elapsed = 0;
          m_tick    = 1'b0;
          m_phase   = 2;
        end
        default: begin
          if (!control) begin
            m_phase = 0; m_tick = 1'b0;
          end else if (pause) begin
            m_tick = 1'b0;
          end else begin
            m_elapsed++;
            m_tick = ((m_elapsed % (period_ms(m_speed) * CYC)) == 0);
          end
        end
      endcase
    end
    #1;
    check("tick",         32'(tick),         32'(m_tick));
    check("running",      32'(running),      32'(m_phase == 2));
    check("active_speed", 32'(active_speed), 32'(m_speed));
    if (running && !prev_run) run_entry = cyc;
    if (tick) tick_log.push_back(cyc - run_entry);
    prev_run = running;
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // --------------------------------------------------------------------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise control with a speed and return on the first negedge with running=1.
  task automatic arm(input logic [1:0] spd);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    game_speed = spd;
    control    = 1'b1;
    tick_log.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (running) begin
        seen = 1'b1;
        break;
      end
    end
    check("arm_timeout", 32'(seen), 32'd1);
  endtask

  task automatic drop_control(input int n);
    @(negedge clk);
    control = 1'b0;
    cycles(n);
  endtask

  task automatic check_log(input string name, input int n, input int e0, input int e1, input int e2);
    int e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    check({name, "_count"}, 32'(tick_log.size()), 32'(n));
    for (int i = 0; i < n && i < tick_log.size(); i++)
      check({name, "_offset"}, 32'(tick_log[i]), 32'(e[i]));
  endtask

  initial begin
    rst = 1'b0; game_speed = 2'b00; control = 1'b0; pause = 1'b0;

    // Reset
    cycles(3);
    check("reset_tick",    32'(tick),         32'd0);
    check("reset_running", 32'(running),      32'd0);
    check("reset_speed",   32'(active_speed), 32'd0);
    rst = 1'b1;

    // Normal: ticks at RUN+20, +40, +60
    arm(2'b00);
    cycles(64);
    check_log("normal", 3, 20, 40, 60);
    check("normal_speed", 32'(active_speed), 32'd0);

    // Advanced, speed change ignored mid-run
    drop_control(3);
    arm(2'b10);
    cycles(9);
    game_speed = 2'b01;
    cycles(21);
    check_log("adv", 3, 8, 16, 24);
    check("adv_speed", 32'(active_speed), 32'd2);

    // Illegal code, drop control just before the first tick
    drop_control(3);
    arm(2'b11);
    check("illegal_speed", 32'(active_speed), 32'd0);
    cycles(19);
    control = 1'b0;
    cycles(3);
    check_log("dropped", 0, 0, 0, 0);
    check("dropped_running", 32'(running), 32'd0);
    arm(2'b01);
    cycles(26);
    check_log("rearm", 2, 12, 24, 0);

    // Pause for 7 cycles starting at RUN+5
    drop_control(3);
    arm(2'b01);
    cycles(4);
    pause = 1'b1;
    cycles(7);
    pause = 1'b0;
    cycles(24);
    check_log("pause", 2, 19, 31, 0);

    // Reset mid-run, control held high across it
    drop_control(3);
    arm(2'b10);
    cycles(6);
    rst = 1'b0;
    cycles(1);
    rst = 1'b1;
    check("midrst_tick",    32'(tick),         32'd0);
    check("midrst_running", 32'(running),      32'd0);
    check("midrst_speed",   32'(active_speed), 32'd0);
    tick_log.delete();
    for (int i = 0; i < 20 && !running; i++) @(negedge clk);
    check("midrst_rearm", 32'(running), 32'd1);
    cycles(17);
    check_log("midrst", 2, 8, 16, 0);

    // Randomized phase; the per-cycle model comparison does the checking
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 199) != 0);
      control    = ($urandom_range(0, 39) != 0);
      pause      = ($urandom_range(0, 4) == 0);
      game_speed = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    rst = 1'b1; control = 1'b0; pause = 1'b0;
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_game_tick_timer
`default_nettype wire

// File: doc/game_tick_timer.md
Name: game_tick_timer

Overview:
- Sits directly downstream of the speed-select stage.
- Consumes the selected 2-bit game speed and its "selection ready" control flag.
- Once control is asserted, it latches the speed and produces a periodic one-cycle tick that paces the random-number/LED game logic.
- Tick period depends on level: Normal slowest, Advanced fastest.

Parameters:
- CYC_PER_MS, 50000, clock cycles per millisecond (50 MHz board clock).
- NORMAL_MS, 1000, tick period in ms for speed 2'b00.
- INTER_MS, 500, tick period in ms for speed 2'b01.
- ADV_MS, 250, tick period in ms for speed 2'b10.
- MS_W, 10, width of the millisecond counter; must satisfy 2^MS_W > max period.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous active-low reset.
- game_speed  input  2  speed code from the upstream selection stage.
- control  input  1  high = selection final; low = idle/clear.
- pause  input  1  high freezes all timing counters in RUN.
- tick  output  1  one-cycle pulse per elapsed period.
- running  output  1  high while in RUN state.
- active_speed  output  2  speed code latched at arm time.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, tick=0, running=0, active_speed=2'b00.
  - Prescaler and ms counter cleared.
  - Reset wins over every other input, including mid-RUN.
- States are IDLE, ARM and RUN.
- IDLE:
  - tick=0, running=0, counters held at 0.
  - control==1 sampled → ARM next cycle.
- ARM (exactly one cycle):
  - active_speed <= game_speed; code 2'b11 maps to 2'b00 (Normal).
  - Counters cleared.
  - → RUN unconditionally, even if control dropped this cycle; IDLE follows from RUN.
- RUN:
  - running=1.
  - Prescaler counts 0..CYC_PER_MS-1 and wraps. On wrap, ms counter increments.
  - When the prescaler wraps with ms counter == period-1: tick=1 for that one cycle, and ms counter returns to 0.
  - period is selected from active_speed.
- Latency: the first tick is registered on the (period*CYC_PER_MS)-th posedge after the edge that entered RUN. Subsequent ticks follow exactly period*CYC_PER_MS cycles apart.
- pause==1 in RUN:
  - Prescaler and ms counter hold; tick=0.
  - On release, counting resumes from the held value, with no lost or extra cycles.
- control==0 sampled in RUN:
  - → IDLE next cycle; tick forced 0 that cycle, even if a tick would have fired.
  - Counters cleared. active_speed retains its last value until the next ARM.
- game_speed changes while in RUN are ignored. A new speed takes effect only after control falls and re-rises (new ARM).
- tick is registered, never combinational from inputs.
- tick is never high in IDLE or ARM, nor on two consecutive cycles.
- Counter widths: the prescaler is $clog2(CYC_PER_MS) bits wide. Neither counter may overflow; comparisons use the exact terminal count.

Decomposition:
- Shared game package holds:
  - Speed codes SPEED_NORMAL=2'b00, SPEED_INTER=2'b01, SPEED_ADV=2'b10. The upstream selection stage uses the same codes.
  - State encoding for IDLE/ARM/RUN.
- One sub-module, ms_prescaler:
  - Inputs: clk, rst, clear, enable.
  - Output: ms_pulse, asserted on the terminal count.
  - Parameter: CYC_PER_MS.
- Top level holds the FSM, speed latch, period mux and ms counter.

Test Plan (bench overrides CYC_PER_MS=4, NORMAL_MS=5, INTER_MS=3, ADV_MS=2):
- Normal: rst low 3 cycles, then game_speed=00, control=1 → ARM one cycle, running=1; tick pulses at RUN+20, +40, +60 cycles, each exactly 1 cycle wide; active_speed=00.
- Advanced with mid-run speed change: game_speed=10, control=1 → ticks every 8 cycles. Set game_speed=01 at cycle 10 → period stays 8.
- Illegal code and re-arm:
  - game_speed=11, control=1 → active_speed=00, ticks every 20 cycles.
  - Drop control at cycle 19 → no tick at cycle 20, running=0.
  - Re-raise with 01 → ticks every 12 cycles.
- Pause: speed 01. Assert pause for 7 cycles starting at RUN+5 → first tick at RUN+19; next tick at RUN+31.
- Reset mid-operation: speed 10. Assert rst low at RUN+7 → tick stays 0, running=0, active_speed=00 next cycle. With control held 1 after release → ARM then RUN; first tick 8 cycles after RUN entry.
